// File: rtl/flt2int.sv
// flt2int: sequential half-precision float to 16-bit signed integer converter.
// A five-state FSM classifies the captured operand, aligns the significand
// one bit per cycle, applies the sign and pulses done for one cycle.
// Out-of-range operands saturate to 0x7FFF / 0x8000; in-range results
// truncate toward zero.
module flt2int #(
  parameter int BIAS = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [15:0]        flt_in,
  output logic signed [15:0] int_out,
  output logic               done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLASSIFY = 3'd1,
    SHIFT    = 3'd2,
    SIGN     = 3'd3,
    DONE     = 3'd4
  } state_t;

  // Exponent thresholds: below EXP_ONE the value is under 1.0, at or above
  // EXP_SAT it no longer fits a signed 16-bit integer, and EXP_UNIT is the
  // exponent at which {1,m} already sits at integer weight (no shift).
  localparam logic [5:0]        EXP_ONE  = 6'(BIAS);
  localparam logic [5:0]        EXP_SAT  = 6'(BIAS + 15);
  localparam logic signed [7:0] EXP_UNIT = 8'(BIAS + 10);

  state_t       state;
  logic         sign_r;
  logic [4:0]   exp_r;
  logic [9:0]   man_r;
  logic [15:0]  mag_r;
  logic [3:0]   cnt_r;
  logic         dir_left_r;

  logic               is_zero;
  logic               is_sat;
  logic signed [7:0]  e_rel;
  logic               left_cls;
  logic [3:0]         n_cls;

  // Saturated result for an operand whose magnitude exceeds the integer range.
  function automatic logic signed [15:0] saturate(input logic s);
    return s ? 16'sh8000 : 16'sh7FFF;
  endfunction

  // Sign application: two's complement of the aligned magnitude when negative.
  function automatic logic signed [15:0] apply_sign(input logic s,
                                                    input logic [15:0] mag);
    return s ? $signed(~mag + 16'd1) : $signed(mag);
  endfunction

  // Classification of the captured exponent and derivation of shift amount.
  always_comb begin
    is_zero  = ({1'b0, exp_r} < EXP_ONE);
    is_sat   = ({1'b0, exp_r} >= EXP_SAT);
    e_rel    = $signed({3'b000, exp_r}) - EXP_UNIT;
    left_cls = (e_rel > 8'sd0);
    n_cls    = left_cls ? e_rel[3:0] : 4'(-e_rel);
  end

  // Conversion FSM with registered result and working registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      int_out    <= '0;
      sign_r     <= 1'b0;
      exp_r      <= '0;
      man_r      <= '0;
      mag_r      <= '0;
      cnt_r      <= '0;
      dir_left_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sign_r <= flt_in[15];
            exp_r  <= flt_in[14:10];
            man_r  <= flt_in[9:0];
            state  <= CLASSIFY;
          end
        end
        CLASSIFY: begin
          if (is_zero) begin
            int_out <= '0;
            state   <= DONE;
          end else if (is_sat) begin
            int_out <= saturate(sign_r);
            state   <= DONE;
          end else begin
            mag_r      <= {5'b00000, 1'b1, man_r};
            cnt_r      <= n_cls;
            dir_left_r <= left_cls;
            state      <= (n_cls != 4'd0) ? SHIFT : SIGN;
          end
        end
        SHIFT: begin
          // Right shifts drop fraction bits: truncation toward zero.
          mag_r <= dir_left_r ? {mag_r[14:0], 1'b0} : {1'b0, mag_r[15:1]};
          cnt_r <= cnt_r - 4'd1;
          if (cnt_r == 4'd1) begin
            state <= SIGN;
          end
        end
        SIGN: begin
          int_out <= apply_sign(sign_r, mag_r);
          state   <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign done = (state == DONE);

endmodule

// File: tb/tb_flt2int.sv
// tb_flt2int: self-checking bench for flt2int with a real-arithmetic model.
module tb_flt2int;

  localparam int BIAS = 15;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] flt_in;
  logic [15:0] int_out;
  logic        done;

  int n_cmp;
  int n_err;

  flt2int #(.BIAS(BIAS)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .flt_in  (flt_in),
    .int_out (int_out),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 2^k as a real number.
  function automatic real pow2(input int k);
    real p;
    p = 1.0;
    if (k >= 0) begin
      for (int i = 0; i < k; i++) p = p * 2.0;
    end else begin
      for (int i = 0; i < -k; i++) p = p / 2.0;
    end
    return p;
  endfunction

  // Reference: value = (-1)^s * 1.m * 2^(e-BIAS), truncated toward zero,
  // saturated to the signed 16-bit range; e==31 always saturates.
  function automatic logic [15:0] ref_conv(input logic [15:0] f);
    int  e;
    int  r;
    real v;
    e = int'(f[14:10]);
    if (e == 31) begin
      r = 32768;
    end else begin
      v = (1.0 + real'(int'(f[9:0])) / 1024.0) * pow2(e - BIAS);
      r = $rtoi(v);
    end
    if (r > 32767) return f[15] ? 16'h8000 : 16'h7FFF;
    return f[15] ? 16'(-r) : 16'(r);
  endfunction

  // Reference latency in edges from acceptance to done being visible.
  function automatic int ref_lat(input logic [15:0] f);
    int e;
    int d;
    e = int'(f[14:10]);
    if (e < BIAS || e > BIAS + 14) return 1;
    d = e - (BIAS + 10);
    return 2 + ((d < 0) ? -d : d);
  endfunction

  // Drive one conversion; report result, latency (-1 on timeout) and done
  // one cycle after the pulse.
  task automatic convert(input logic [15:0] f, output logic [15:0] res,
                         output int lat, output logic done_after,
                         output logic [15:0] held);
    lat = -1;
    res = 16'hxxxx;
    @(negedge clk);
    flt_in = f;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = i;
        res = int_out;
        break;
      end
    end
    @(posedge clk);
    @(negedge clk);
    done_after = done;
    held       = int_out;
  endtask

  task automatic test_reset;
    reset  = 1'b0;
    start  = 1'b0;
    flt_in = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (int_out !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_int_out got=%h want=0000", int_out);
    end
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_done got=%b want=0", done);
    end
    reset = 1'b1;
  endtask

  task automatic test_directed;
    logic [15:0] fv [13] = '{16'h3C00, 16'h6400, 16'h7780, 16'hC880, 16'h3E00,
                             16'h3800, 16'h8000, 16'hF800, 16'h7C00, 16'h7BFF,
                             16'h77FF, 16'hF7FF, 16'h0001};
    logic [15:0] ev [13] = '{16'h0001, 16'h0400, 16'h7800, 16'hFFF7, 16'h0001,
                             16'h0000, 16'h0000, 16'h8000, 16'h7FFF, 16'h7FFF,
                             16'h7FF0, 16'h8010, 16'h0000};
    int          lv [13] = '{12, 2, 6, 9, 12, 1, 1, 1, 1, 1, 6, 6, 1};
    logic [15:0] res;
    logic [15:0] held;
    int          lat;
    logic        da;
    for (int k = 0; k < 13; k++) begin
      convert(fv[k], res, lat, da, held);
      n_cmp++;
      if (res !== ev[k]) begin
        n_err++;
        $display("FAIL directed_value in=%h got=%h want=%h", fv[k], res, ev[k]);
      end
      n_cmp++;
      if (lat != lv[k]) begin
        n_err++;
        $display("FAIL directed_latency in=%h got=%0d want=%0d", fv[k], lat, lv[k]);
      end
      n_cmp++;
      if (da !== 1'b0) begin
        n_err++;
        $display("FAIL directed_done_width in=%h done_next=%b want=0", fv[k], da);
      end
      n_cmp++;
      if (held !== ev[k]) begin
        n_err++;
        $display("FAIL directed_hold in=%h got=%h want=%h", fv[k], held, ev[k]);
      end
    end
  endtask

  task automatic test_random;
    logic [15:0] f;
    logic [15:0] res;
    logic [15:0] held;
    int          lat;
    logic        da;
    for (int k = 0; k < 150; k++) begin
      f = 16'($urandom);
      convert(f, res, lat, da, held);
      n_cmp++;
      if (res !== ref_conv(f)) begin
        n_err++;
        $display("FAIL random_value in=%h got=%h want=%h", f, res, ref_conv(f));
      end
      n_cmp++;
      if (lat != ref_lat(f)) begin
        n_err++;
        $display("FAIL random_latency in=%h got=%0d want=%0d", f, lat, ref_lat(f));
      end
    end
  endtask

  task automatic test_handshake;
    int          pulses;
    int          first_at;
    int          second_at;
    logic [15:0] vals [2];
    pulses    = 0;
    first_at  = -1;
    second_at = -1;
    vals[0]   = 16'hxxxx;
    vals[1]   = 16'hxxxx;
    @(negedge clk);
    flt_in = 16'h3C00;
    start  = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 3)  flt_in = 16'h7C00;
      if (c == 12) flt_in = 16'h3C00;
      if (c == 20) start = 1'b0;
      if (done) begin
        if (pulses < 2) vals[pulses] = int_out;
        if (pulses == 0) first_at = c;
        else if (pulses == 1) second_at = c;
        pulses++;
      end
    end
    n_cmp++;
    if (pulses != 2) begin
      n_err++;
      $display("FAIL handshake_pulses got=%0d want=2", pulses);
    end
    n_cmp++;
    if (first_at != 13) begin
      n_err++;
      $display("FAIL handshake_first_at got=%0d want=13", first_at);
    end
    n_cmp++;
    if (second_at != 27) begin
      n_err++;
      $display("FAIL handshake_second_at got=%0d want=27", second_at);
    end
    n_cmp++;
    if (vals[0] !== 16'h0001 || vals[1] !== 16'h0001) begin
      n_err++;
      $display("FAIL handshake_values got=%h,%h want=0001,0001", vals[0], vals[1]);
    end
  endtask

  task automatic test_reset_midop;
    logic [15:0] res;
    logic [15:0] held;
    int          lat;
    logic        da;
    logic        saw_done;
    convert(16'h7780, res, lat, da, held);
    saw_done = 1'b0;
    @(negedge clk);
    flt_in = 16'h3C00;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) saw_done = 1'b1;
      if (k == 4) reset = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    n_cmp++;
    if (int_out !== 16'h0000) begin
      n_err++;
      $display("FAIL midop_reset_int_out got=%h want=0000", int_out);
    end
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    n_cmp++;
    if (saw_done !== 1'b0) begin
      n_err++;
      $display("FAIL midop_no_done got=%b want=0", saw_done);
    end
    convert(16'h6400, res, lat, da, held);
    n_cmp++;
    if (res !== 16'h0400 || lat != 2) begin
      n_err++;
      $display("FAIL midop_restart got=%h lat=%0d want=0400 lat=2", res, lat);
    end
  endtask

  task automatic test_reset_priority;
    int   seen_at;
    logic early;
    seen_at = -1;
    early   = 1'b0;
    convert_dummy_prep();
    @(negedge clk);
    reset  = 1'b0;
    start  = 1'b1;
    flt_in = 16'h6400;
    @(posedge clk);
    @(negedge clk);
    if (done) early = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done && seen_at < 0) seen_at = k;
    end
    n_cmp++;
    if (early !== 1'b0) begin
      n_err++;
      $display("FAIL priority_done_under_reset got=%b want=0", early);
    end
    n_cmp++;
    if (seen_at != 2) begin
      n_err++;
      $display("FAIL priority_first_start_after_reset lat=%0d want=2", seen_at);
    end
    n_cmp++;
    if (int_out !== 16'h0400) begin
      n_err++;
      $display("FAIL priority_value got=%h want=0400", int_out);
    end
  endtask

  // Leave a nonzero result behind so the reset-priority case starts busy-free.
  task automatic convert_dummy_prep;
    logic [15:0] res;
    logic [15:0] held;
    int          lat;
    logic        da;
    convert(16'hC880, res, lat, da, held);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset;
    test_directed;
    test_random;
    test_handshake;
    test_reset_midop;
    test_reset_priority;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/flt2int.md
FLT2INT -- requirements
Module: flt2int

Interface
REQ-001 SHALL provide parameter: BIAS, 15, exponent bias of the input float format.
REQ-002 SHALL provide port: clk  input  1  rising-edge clock; one clock domain only.
REQ-003 SHALL provide port: reset  input  1  synchronous, active-low reset (sampled on clk rising edge when 0).
REQ-004 SHALL provide port: start  input  1  conversion request, sampled only in IDLE.
REQ-005 SHALL provide port: flt_in  input  16  float operand: [15] sign, [14:10] biased exponent e, [9:0] mantissa m, hidden 1.
REQ-006 SHALL provide port: int_out  output  16  two's-complement integer result, registered.
REQ-007 SHALL provide port: done  output  1  completion flag, high exactly one cycle per accepted start.

Function
REQ-008 SHALL implement the FSM states IDLE, CLASSIFY, SHIFT, SIGN and DONE; done SHALL be (state==DONE), decoded from the state register.
REQ-009 In IDLE with start=1 at edge T, SHALL capture flt_in into internal registers and enter CLASSIFY; start SHALL be ignored in every other state.
REQ-010 CLASSIFY, zero class: e < BIAS (includes e=0, +/-0, subnormals); SHALL load int_out=0x0000 and enter DONE at edge T+1.
REQ-011 CLASSIFY, saturate class: e > BIAS+14; SHALL load int_out=0x7FFF if sign=0 and 0x8000 if sign=1, including e=BIAS+15 with m=0 and any e=31, then enter DONE at edge T+1.
REQ-012 CLASSIFY, normal class: BIAS <= e <= BIAS+14; SHALL load the 16-bit magnitude register with {5'b0,1'b1,m}.
REQ-013 CLASSIFY, normal class: SHALL load shift count N=|e-(BIAS+10)| (4-bit) and the shift direction (left if e>BIAS+10, else right).
REQ-014 CLASSIFY, normal class: SHALL enter SHIFT if N>0, else SIGN.
REQ-015 SHIFT SHALL shift the magnitude register one bit per cycle in the latched direction; right shifts SHALL discard fraction bits, giving truncation toward zero with no rounding.
REQ-016 SHIFT SHALL decrement N each cycle and leave for SIGN on the edge that performs the last shift; the state occupies exactly N cycles.
REQ-017 SIGN SHALL load int_out with the magnitude if sign=0, else with its two's complement (~mag+1), and enter DONE.
REQ-018 Normal-class latency: done SHALL be high in the cycle after edge T+2+N, max 12 cycles (e=BIAS).
REQ-019 Special-class latency: done SHALL be high in the cycle after edge T+1.
REQ-020 DONE SHALL return to IDLE on the next edge unconditionally; a start seen in DONE SHALL be ignored.
REQ-021 int_out SHALL change only when loaded in CLASSIFY (special class) or SIGN, and SHALL hold its value through IDLE until the next conversion loads it.
REQ-022 Normal-class magnitude SHALL never exceed 0x7FF0; no overflow check is needed after SHIFT.

Reset
REQ-023 With reset=0 at a rising edge, SHALL force state=IDLE, int_out=0x0000, done=0, and clear internal registers.
REQ-024 Reset in any state, including mid-SHIFT, SHALL abort the conversion with no done pulse; start SHALL be accepted on the first edge with reset=1.
REQ-025 Reset SHALL take priority over start on the same edge.

Verification
REQ-026 Exact conversions (BIAS=15): flt_in=0x3C00 -> 0x0001, done after T+12; 0x6400 -> 0x0400, done after T+2; 0x7780 -> 0x7800, done after T+6.
REQ-027 Negative and truncation: 0xC880 -> 0xFFF7 (-9), done after T+9; 0x3E00 (1.5) -> 0x0001.
REQ-028 Special class: 0x3800 (0.5) -> 0x0000 and 0x8000 (-0) -> 0x0000; 0xF800 -> 0x8000 and 0x7C00 -> 0x7FFF; each done after T+1.
REQ-029 Handshake: hold start=1 for 20 cycles on 0x3C00 -> exactly 2 done pulses, the second restart accepted in the IDLE cycle after DONE; a flt_in change while busy does not alter the result.
REQ-030 Reset mid-op: start 0x3C00, drive reset=0 at T+5 -> int_out=0x0000, no done pulse; then start 0x6400 -> 0x0400.
